// File: rtl/axis_pulse_generator_if.sv
// AXI-Stream sample bus from the pulse generator to the DAC or loopback path.
// The master drives tdata/tvalid/tlast; the slave returns tready.
interface axis_pulse_generator_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pulse_generator.sv
// Trapezoidal pulse-train AXI-Stream source; first sample 1 cycle after enable, registered outputs.
// Backpressure: tready low stalls the segment counters, so timing is counted in accepted samples.
module axis_pulse_generator #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int PULSE_WIDTH      = 16,
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                                               aclk,
  input  logic                                               areset,
  input  logic [PULSE_WIDTH*3+AXIS_TDATA_WIDTH*3+32-1:0]     cfg_data,
  input  logic                                               enable,
  output logic                                               busy,
  output logic [31:0]                                        sts_data,
  axis_pulse_generator_if.master                             m_axis
);

  localparam int DW = AXIS_TDATA_WIDTH;
  localparam logic [CNTR_WIDTH-1:0] CNT_ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [31:0]            pulse_count;
    logic [DW-1:0]          ramp_step;
    logic [DW-1:0]          top;
    logic [DW-1:0]          baseline;
    logic [PULSE_WIDTH-1:0] width;
    logic [PULSE_WIDTH-1:0] ramp;
    logic [PULSE_WIDTH-1:0] offset_start;
  } cfg_t;

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_PRE, S_UP, S_TOP, S_DOWN, S_POST
  } state_t;

  cfg_t                  cfg_in, cfg_q, cfg_d, ld_cfg;
  state_t                state_q, state_d, nxt;
  logic [CNTR_WIDTH-1:0] seg_cnt_q, seg_cnt_d;
  logic [DW-1:0]         tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  busy_q;
  logic [31:0]           sts_q, sts_d;
  logic                  adv, seg_end, stop, load, go_idle;

  assign cfg_in = cfg_t'(cfg_data);

  function automatic logic [CNTR_WIDTH-1:0] seg_len(input state_t s, input cfg_t c);
    logic [CNTR_WIDTH-1:0] r;
    r = '0;
    case (s)
      S_DELAY:        r = CNTR_WIDTH'(c.offset_start);
      S_PRE, S_POST:  r = CNTR_WIDTH'(c.width >> 1);
      S_UP, S_DOWN:   r = CNTR_WIDTH'(c.ramp);
      S_TOP:          r = CNTR_WIDTH'(c.width);
      default:        r = '0;
    endcase
    return r;
  endfunction

  // First non-empty segment strictly after 'from'; S_IDLE when none remains.
  function automatic state_t next_seg(input state_t from, input cfg_t c);
    state_t r;
    r = S_IDLE;
    for (int i = 6; i >= 1; i--) begin
      if (i > int'(from) && seg_len(state_t'(i[2:0]), c) != '0)
        r = state_t'(i[2:0]);
    end
    return r;
  endfunction

  function automatic logic is_last(input state_t s, input logic [CNTR_WIDTH-1:0] cnt,
                                   input cfg_t c);
    return (s != S_DELAY) && (cnt + CNT_ONE == seg_len(s, c)) && (next_seg(s, c) == S_IDLE);
  endfunction

  // One saturating ramp step, computed one bit wider than the sample.
  function automatic logic [DW-1:0] sat_step(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic sub);
    logic [DW:0]   s;
    logic [DW-1:0] r;
    s = sub ? ({a[DW-1], a} - {b[DW-1], b}) : ({a[DW-1], a} + {b[DW-1], b});
    if (s[DW] != s[DW-1])
      r = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      r = s[DW-1:0];
    return r;
  endfunction

  function automatic logic [DW-1:0] entry_sample(input state_t s, input cfg_t c);
    logic [DW-1:0] r;
    case (s)
      S_UP:    r = sat_step(c.baseline, c.ramp_step, 1'b0);
      S_DOWN:  r = sat_step(c.top, c.ramp_step, 1'b1);
      S_TOP:   r = c.top;
      default: r = c.baseline;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    seg_cnt_d = seg_cnt_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    sts_d     = sts_q;
    cfg_d     = cfg_q;
    nxt       = S_IDLE;
    ld_cfg    = cfg_q;
    load      = 1'b0;
    go_idle   = 1'b0;
    stop      = 1'b0;
    adv       = tvalid_q & m_axis.tready;
    seg_end   = (seg_cnt_q + CNT_ONE == seg_len(state_q, cfg_q));

    if (state_q == S_IDLE) begin
      nxt    = next_seg(S_IDLE, cfg_in);
      ld_cfg = cfg_in;
      if (enable && nxt != S_IDLE) begin
        load  = 1'b1;
        sts_d = '0;
      end
    end else if (adv) begin
      if (!seg_end) begin
        seg_cnt_d = seg_cnt_q + CNT_ONE;
        tlast_d   = is_last(state_q, seg_cnt_q + CNT_ONE, cfg_q);
        if (state_q == S_UP)
          tdata_d = sat_step(tdata_q, cfg_q.ramp_step, 1'b0);
        else if (state_q == S_DOWN)
          tdata_d = sat_step(tdata_q, cfg_q.ramp_step, 1'b1);
      end else if (tlast_q) begin
        // Period boundary: fresh config is sampled here and governs the next period.
        sts_d = sts_q + 32'd1;
        stop  = ((cfg_q.pulse_count != 32'd0) && (sts_q + 32'd1 == cfg_q.pulse_count)) || !enable;
        if (!stop) begin
          nxt    = next_seg(S_DELAY, cfg_in);
          ld_cfg = cfg_in;
        end
        load    = (nxt != S_IDLE);
        go_idle = (nxt == S_IDLE);
      end else begin
        nxt     = next_seg(state_q, cfg_q);
        load    = (nxt != S_IDLE);
        go_idle = (nxt == S_IDLE);
      end
    end

    if (load) begin
      state_d   = nxt;
      cfg_d     = ld_cfg;
      seg_cnt_d = '0;
      tdata_d   = entry_sample(nxt, ld_cfg);
      tvalid_d  = 1'b1;
      tlast_d   = is_last(nxt, '0, ld_cfg);
    end else if (go_idle) begin
      state_d   = S_IDLE;
      seg_cnt_d = '0;
      tvalid_d  = 1'b0;
      tlast_d   = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= S_IDLE;
      seg_cnt_q <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      sts_q     <= '0;
      cfg_q     <= '0;
    end else begin
      state_q   <= state_d;
      seg_cnt_q <= seg_cnt_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      busy_q    <= (state_d != S_IDLE);
      sts_q     <= sts_d;
      cfg_q     <= cfg_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign busy          = busy_q;
  assign sts_data      = sts_q;

endmodule

// File: tb/tb_axis_pulse_generator.sv
// Directed bench for axis_pulse_generator: a scoreboard of expected samples is
// filled when each run is started and drained by a monitor on every accepted beat.
module tb_axis_pulse_generator;

  localparam int DW = 16;
  localparam int PW = 16;

  typedef struct {
    logic [15:0] d;
    logic        l;
    logic [31:0] s;
  } exp_t;

  logic                        aclk = 1'b0;
  logic                        areset = 1'b1;
  logic [PW*3+DW*3+32-1:0]     cfg_data;
  logic                        enable;
  logic                        busy;
  logic [31:0]                 sts_data;

  axis_pulse_generator_if #(.DATA_WIDTH(DW)) m_axis ();

  axis_pulse_generator #(
    .AXIS_TDATA_WIDTH(DW),
    .PULSE_WIDTH(PW),
    .CNTR_WIDTH(32)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .cfg_data(cfg_data),
    .enable(enable),
    .busy(busy),
    .sts_data(sts_data),
    .m_axis(m_axis)
  );

  always #5 aclk = ~aclk;

  int   checks = 0;
  int   errors = 0;
  int   n_acc  = 0;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic set_cfg(input int off, input int ramp, input int width, input int base,
                         input int top, input int step, input int pc);
    cfg_data = {32'(pc), 16'(step), 16'(top), 16'(base), 16'(width), 16'(ramp), 16'(off)};
  endtask

  // Reference trapezoid for one period; off>0 prepends the lead delay.
  task automatic push_period(input int off, input int ramp, input int width, input int base,
                             input int top, input int step, input int sts);
    exp_t tmp[$];
    int   acc;
    int   half;
    half = width / 2;
    for (int k = 0; k < half; k++) tmp.push_back('{d: 16'(base), l: 1'b0, s: 32'(sts)});
    acc = base;
    for (int k = 0; k < ramp; k++) begin
      acc = sat(acc + step);
      tmp.push_back('{d: 16'(acc), l: 1'b0, s: 32'(sts)});
    end
    for (int k = 0; k < width; k++) tmp.push_back('{d: 16'(top), l: 1'b0, s: 32'(sts)});
    acc = top;
    for (int k = 0; k < ramp; k++) begin
      acc = sat(acc - step);
      tmp.push_back('{d: 16'(acc), l: 1'b0, s: 32'(sts)});
    end
    for (int k = 0; k < half; k++) tmp.push_back('{d: 16'(base), l: 1'b0, s: 32'(sts)});
    if (tmp.size() > 0) tmp[tmp.size()-1].l = 1'b1;
    for (int k = 0; k < off; k++) exp_q.push_back('{d: 16'(base), l: 1'b0, s: 32'(sts)});
    foreach (tmp[i]) exp_q.push_back(tmp[i]);
  endtask

  // Monitor: pops on every accepted beat and checks held outputs across stalls.
  logic        stall_pend = 1'b0;
  logic [15:0] stall_d;
  logic        stall_l;
  always @(negedge aclk) begin
    exp_t e;
    if (areset) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_tdata", 32'(m_axis.tdata), 32'(stall_d));
        check("stall_tlast", 32'(m_axis.tlast), 32'(stall_l));
        check("stall_tvalid", 32'(m_axis.tvalid), 32'd1);
      end
      stall_pend = m_axis.tvalid && !m_axis.tready;
      stall_d    = m_axis.tdata;
      stall_l    = m_axis.tlast;
      if (m_axis.tvalid && m_axis.tready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_sample: observed tdata %0h, expected no sample", m_axis.tdata);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tdata", 32'(m_axis.tdata), 32'(e.d));
          check("tlast", 32'(m_axis.tlast), 32'(e.l));
          check("sts_during", sts_data, e.s);
        end
        n_acc++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic wait_done(input bit rnd, input int budget);
    int k;
    k = 0;
    do begin
      @(posedge aclk);
      #1;
      m_axis.tready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      k++;
    end while (!(exp_q.size() == 0 && !busy) && k < budget);
    checks++;
    assert (k < budget) else begin
      errors++;
      $error("FAIL timeout_done: observed %0d cycles, expected fewer than %0d", k, budget);
    end
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k;
    k = 0;
    while (n_acc < n && k < budget) begin
      @(posedge aclk);
      #1;
      k++;
    end
    checks++;
    assert (k < budget) else begin
      errors++;
      $error("FAIL timeout_acc: observed %0d samples, expected %0d", n_acc, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    enable        = 1'b0;
    m_axis.tready = 1'b1;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
    check("rst_tdata", 32'(m_axis.tdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sts", sts_data, 32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    cyc(2);

    // Single period, free-flowing sink
    set_cfg(2, 2, 4, 0, 100, 40, 1);
    push_period(2, 2, 4, 0, 100, 40, 0);
    n0 = n_acc;
    enable = 1'b1;
    wait_done(1'b0, 200);
    enable = 1'b0;
    cyc(3);
    check("t1_count", 32'(n_acc - n0), 32'd14);
    check("t1_sts", sts_data, 32'd1);
    check("t1_tvalid_after", 32'(m_axis.tvalid), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);

    // Same period with random backpressure
    push_period(2, 2, 4, 0, 100, 40, 0);
    n0 = n_acc;
    enable = 1'b1;
    wait_done(1'b1, 600);
    enable = 1'b0;
    m_axis.tready = 1'b1;
    cyc(2);
    check("t2_count", 32'(n_acc - n0), 32'd14);
    check("t2_sts", sts_data, 32'd1);

    // Three periods, top changed during the first
    set_cfg(0, 2, 4, 0, 100, 40, 3);
    push_period(0, 2, 4, 0, 100, 40, 0);
    push_period(0, 2, 4, 0, 50, 40, 1);
    push_period(0, 2, 4, 0, 50, 40, 2);
    n0 = n_acc;
    enable = 1'b1;
    wait_acc(n0 + 3, 100);
    set_cfg(0, 2, 4, 0, 50, 40, 3);
    wait_done(1'b0, 300);
    enable = 1'b0;
    cyc(2);
    check("t3_count", 32'(n_acc - n0), 32'd36);
    check("t3_sts", sts_data, 32'd3);

    // Continuous mode, enable dropped mid-period: period completes
    set_cfg(2, 2, 4, 0, 100, 40, 0);
    push_period(2, 2, 4, 0, 100, 40, 0);
    n0 = n_acc;
    enable = 1'b1;
    wait_acc(n0 + 5, 100);
    enable = 1'b0;
    wait_done(1'b0, 200);
    cyc(2);
    check("stop_count", 32'(n_acc - n0), 32'd14);
    check("stop_sts", sts_data, 32'd1);
    check("stop_tvalid", 32'(m_axis.tvalid), 32'd0);

    // Single-sample periods, one per cycle
    set_cfg(0, 0, 1, 0, 77, 5, 5);
    for (int i = 0; i < 5; i++) push_period(0, 0, 1, 0, 77, 5, i);
    enable = 1'b1;
    wait_done(1'b0, 100);
    enable = 1'b0;
    cyc(2);
    check("t4_sts", sts_data, 32'd5);

    // Positive and negative saturation
    set_cfg(0, 3, 2, 0, 32767, 20000, 1);
    push_period(0, 3, 2, 0, 32767, 20000, 0);
    enable = 1'b1;
    wait_done(1'b0, 100);
    enable = 1'b0;
    cyc(2);
    set_cfg(0, 3, 2, -32768, -30000, 20000, 1);
    push_period(0, 3, 2, -32768, -30000, 20000, 0);
    enable = 1'b1;
    wait_done(1'b0, 100);
    enable = 1'b0;
    cyc(2);
    check("t5_sts", sts_data, 32'd1);

    // All segments empty: start ignored
    set_cfg(0, 0, 0, 5, 5, 5, 0);
    enable = 1'b1;
    cyc(4);
    check("zero_tvalid", 32'(m_axis.tvalid), 32'd0);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_sts", sts_data, 32'd1);
    enable = 1'b0;
    cyc(2);

    // Asynchronous reset mid-TOP, then replay from the lead delay
    set_cfg(2, 2, 4, 0, 100, 40, 0);
    push_period(2, 2, 4, 0, 100, 40, 0);
    n0 = n_acc;
    enable = 1'b1;
    wait_acc(n0 + 7, 100);
    check("t6_pre_tdata", 32'(m_axis.tdata), 32'd100);
    #2;
    areset = 1'b1;
    #1;
    check("t6_rst_tvalid", 32'(m_axis.tvalid), 32'd0);
    check("t6_rst_tdata", 32'(m_axis.tdata), 32'd0);
    check("t6_rst_tlast", 32'(m_axis.tlast), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_sts", sts_data, 32'd0);
    exp_q.delete();
    set_cfg(2, 2, 4, 0, 100, 40, 1);
    push_period(2, 2, 4, 0, 100, 40, 0);
    cyc(2);
    n0 = n_acc;
    areset = 1'b0;
    wait_done(1'b0, 200);
    enable = 1'b0;
    cyc(2);
    check("t6_count", 32'(n_acc - n0), 32'd14);
    check("t6_sts", sts_data, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pulse_generator.md
Name: axis_pulse_generator

Overview:
- AXI-Stream master that synthesises a repeating trapezoidal pulse train with ramp-up, flat top and ramp-down.
- It is the transmit-side counterpart of the pulse measurement path: its segment timing (lead delay, half-width baseline, ramp, width, ramp, half-width baseline) matches what the measurer integrates.
- Drives the DAC stream or loopback; pulse count is reported to the PS via sts_data.

Parameters:
AXIS_TDATA_WIDTH, 16, sample width, signed two's complement
PULSE_WIDTH, 16, width of the timing fields offset_start, ramp and width
CNTR_WIDTH, 32, width of the internal segment and pulse counters

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
cfg_data  in  PULSE_WIDTH*3+AXIS_TDATA_WIDTH*3+32  fields, LSB first: offset_start, ramp, width, baseline, top, ramp_step, pulse_count[31:0]
enable  in  1  level; run request
busy  out  1  high whenever the state is not IDLE
sts_data  out  32  number of completed pulse periods since leaving IDLE
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  AXIS_TDATA_WIDTH  sample
m_axis_tvalid  out  1  sample valid
m_axis_tlast  out  1  last sample of a pulse period

Behaviour:
- Reset (async, areset=1): state=IDLE; tvalid=0, tlast=0, tdata=0, busy=0, sts_data=0, all counters=0. Reset mid-pulse aborts immediately; there is no drain.
- All outputs are registered. "Advance" means tvalid&tready in a cycle. Without advance, tdata, tvalid and tlast hold.
- Config latch: all cfg fields are captured on IDLE->DELAY and again at every POST->PRE wrap. cfg changes therefore take effect at the next pulse period.
- half = width>>1. Segment lengths:
  - DELAY = offset_start (first period only)
  - PRE = half
  - UP = ramp
  - TOP = width
  - DOWN = ramp
  - POST = half
- A zero-length segment is skipped with no cycle and no sample.
- The state sequence is IDLE -> DELAY -> PRE -> UP -> TOP -> DOWN -> POST -> (PRE | IDLE).
- If every segment is zero, the block stays in IDLE and the start is ignored.
- IDLE: tvalid=0. When enable=1, the next cycle loads the first non-empty segment, sets tvalid=1 and clears sts_data. The first sample is valid 1 cycle after enable rises.
- Sample values:
  - DELAY, PRE, POST: baseline.
  - TOP: top.
  - UP sample k (0-based): acc = baseline + (k+1)*ramp_step.
  - DOWN sample k: acc = top - (k+1)*ramp_step.
  - acc is formed by repeated add/sub in AXIS_TDATA_WIDTH+1 bits and saturated to the signed range at every step. No clamping to top/baseline is applied.
- Segment counter: increments per advance. On advance of the last sample of a segment, the counter resets to 0 and the state moves to the next non-empty segment. This costs no bubble cycle.
- tlast=1 on the last sample of each period. This is the last POST sample, or the last sample of the final non-empty segment if POST is empty. DELAY is never tlast.
- sts_data increments on advance of the tlast sample. It wraps at 2^32.
- Termination, checked at the tlast advance:
  - If pulse_count!=0 and sts_data+1==pulse_count, go to IDLE.
  - If enable==0, go to IDLE.
  - Otherwise wrap to PRE.
  - When entering IDLE, tvalid drops the next cycle. Simultaneous completion and enable drop both give IDLE.
- enable deasserted mid-period: the current period completes in full (graceful stop), then IDLE.
- pulse_count=0: continuous operation.
- tready held low: the generator stalls indefinitely, with no sample loss and no timing drift. Timing is counted in samples, not cycles.

Test Plan:
1. offset_start=2, ramp=2, width=4, baseline=0, top=100, step=40, pulse_count=1, tready=1 -> exactly 14 samples: 0,0,0,0,40,80,100,100,100,100,60,20,0,0; tlast only on sample 14; sts_data=1; tvalid low afterwards.
2. Same cfg with tready toggled pseudo-randomly -> identical sample sequence; tdata is stable on every stall cycle.
3. pulse_count=3, offset_start=0 -> 36 samples, tlast at samples 12, 24 and 36, sts_data=3. Change top to 50 during pulse 1 -> pulse 2 shows top=50 and pulse 1 is unchanged.
4. ramp=0, width=1 (half=0) -> each period is a single sample equal to top, with tlast=1. sts_data counts every cycle under continuous enable.
5. top=32767, step=20000, ramp=3, baseline=0 -> UP samples 20000, 32767, 32767 (saturated). baseline=-32768 with the DOWN segment saturates at -32768.
6. areset asserted mid-TOP -> all outputs are 0 on the same edge with no clock needed. After release with enable=1, the first-period DELAY is replayed.
